// File: rtl/cavlc_stream_packer.sv
// Multi-lane CAVLC block-code packer: round-robin lane arbitration, MSB-first packing into OUT_W-bit words, flush.
// Optional per-lane/total statistics counters are built when CAVLC_PACK_STAT_EN is defined.
module cavlc_stream_packer #(
    parameter int NUM_CH = 2,
    parameter int CODE_W = 128,
    parameter int LEN_W  = 8,
    parameter int OUT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*CODE_W-1:0]     in_code,
    input  logic [NUM_CH*LEN_W-1:0]      in_len,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_last,
    output logic [$clog2(OUT_W+1)-1:0]   out_bits
`ifdef CAVLC_PACK_STAT_EN
    ,
    output logic [NUM_CH*16-1:0]         stat_blocks,
    output logic [31:0]                  stat_bits
`endif
);

    localparam int OB_W  = $clog2(OUT_W + 1);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW    = (LEN_W > OB_W) ? LEN_W : OB_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [OB_W-1:0]     fill_q, fill_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [LEN_W-1:0]    rem_q, rem_d;

    logic                full_s;
    logic                grant_vld_s;
    logic [PTR_W-1:0]    grant_s;
    logic                hs_s;
    logic [CODE_W-1:0]   code_sel_s;
    logic [CODE_W-1:0]   code_aligned_s;
    logic [LEN_W-1:0]    len_sel_s;
    logic [LEN_W-1:0]    len_eff_s;
    logic [OB_W-1:0]     space_s;
    logic [CW-1:0]       k_s;
    logic [OUT_W+CODE_W-1:0] window_s;
    logic [OUT_W-1:0]    chunk_s;
    logic [OUT_W-1:0]    ins_s;

    assign full_s = (fill_q == OB_W'(OUT_W));

    // Round-robin search: first valid lane at or after the pointer.
    always_comb begin
        int idx;
        idx         = 0;
        grant_vld_s = 1'b0;
        grant_s     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_q) + i) % NUM_CH;
            if (!grant_vld_s && in_valid[idx]) begin
                grant_vld_s = 1'b1;
                grant_s     = PTR_W'(idx);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Lane acceptance; flush and a pending full word both block new blocks.
    always_comb begin
        hs_s           = (state_q == S_IDLE) && !rst && !flush_req && !full_s && grant_vld_s;
        code_sel_s     = in_code[int'(grant_s)*CODE_W +: CODE_W];
        len_sel_s      = in_len[int'(grant_s)*LEN_W +: LEN_W];
        len_eff_s      = (len_sel_s > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : len_sel_s;
        // Left-align so the first bit to send sits at code_q[CODE_W-1].
        code_aligned_s = code_sel_s << (LEN_W'(CODE_W) - len_eff_s);
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = hs_s && (grant_s == PTR_W'(i));
        end
    end

    // Bits moved this cycle: the top k bits of the pending code, dropped below the current fill.
    always_comb begin
        space_s  = OB_W'(OUT_W) - fill_q;
        if (CW'(rem_q) < CW'(space_s)) begin
            k_s = CW'(rem_q);
        end else begin
            k_s = CW'(space_s);
        end
        window_s = {code_q, {OUT_W{1'b0}}};
        chunk_s  = window_s[OUT_W+CODE_W-1 -: OUT_W];
        ins_s    = (chunk_s & ~({OUT_W{1'b1}} >> k_s)) >> fill_q;
    end

    // Next-state and flush handshake.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        fill_d     = fill_q;
        rr_d       = rr_q;
        code_d     = code_q;
        rem_d      = rem_q;
        flush_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full_s) begin
                    if (out_ready) begin
                        acc_d  = '0;
                        fill_d = '0;
                    end else begin
                        acc_d  = acc_q;
                    end
                end else if (flush_req) begin
                    state_d = S_FLUSH;
                end else if (hs_s) begin
                    code_d  = code_aligned_s;
                    rem_d   = len_eff_s;
                    rr_d    = (grant_s == PTR_W'(NUM_CH - 1)) ? '0 : grant_s + PTR_W'(1);
                    state_d = (len_eff_s == '0) ? S_IDLE : S_PACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PACK: begin
                if (full_s) begin
                    if (out_ready) begin
                        acc_d  = '0;
                        fill_d = '0;
                    end else begin
                        acc_d  = acc_q;
                    end
                end else begin
                    acc_d  = acc_q | ins_s;
                    fill_d = fill_q + OB_W'(k_s);
                    rem_d  = rem_q - LEN_W'(k_s);
                    code_d = code_q << k_s;
                    if (CW'(rem_q) == k_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PACK;
                    end
                end
            end
            S_FLUSH: begin
                if (fill_q == '0) begin
                    flush_done = 1'b1;
                    state_d    = S_IDLE;
                end else if (out_ready) begin
                    flush_done = 1'b1;
                    acc_d      = '0;
                    fill_d     = '0;
                    state_d    = S_IDLE;
                end else begin
                    state_d    = S_FLUSH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode straight from the accumulator registers, so it holds stable under backpressure.
    always_comb begin
        if (state_q == S_FLUSH) begin
            out_valid = (fill_q != '0);
            out_last  = (fill_q != '0);
        end else begin
            out_valid = full_s;
            out_last  = 1'b0;
        end
        out_data = acc_q;
        out_bits = out_valid ? fill_q : '0;
    end

    // Datapath and FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            fill_q  <= '0;
            rr_q    <= '0;
            code_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            rr_q    <= rr_d;
            code_q  <= code_d;
            rem_q   <= rem_d;
        end
    end

`ifdef CAVLC_PACK_STAT_EN
    logic [NUM_CH*16-1:0] stat_blocks_q, stat_blocks_d;
    logic [31:0]          stat_bits_q, stat_bits_d;

    // Counters advance on every accepted block, including zero-length ones.
    always_comb begin
        stat_blocks_d = stat_blocks_q;
        stat_bits_d   = stat_bits_q;
        if (hs_s) begin
            stat_blocks_d[int'(grant_s)*16 +: 16] = stat_blocks_q[int'(grant_s)*16 +: 16] + 16'd1;
            stat_bits_d = stat_bits_q + 32'(len_eff_s);
        end else begin
            stat_bits_d = stat_bits_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_blocks_q <= '0;
            stat_bits_q   <= '0;
        end else begin
            stat_blocks_q <= stat_blocks_d;
            stat_bits_q   <= stat_bits_d;
        end
    end

    assign stat_blocks = stat_blocks_q;
    assign stat_bits   = stat_bits_q;
`endif

endmodule

// File: tb/tb_cavlc_stream_packer.sv
// Directed bench for cavlc_stream_packer (NUM_CH=2, CODE_W=128, LEN_W=8, OUT_W=32).
module tb_cavlc_stream_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [255:0] in_code;
    logic [15:0]  in_len;
    logic         flush_req;
    logic         flush_done;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [5:0]   out_bits;
`ifdef CAVLC_PACK_STAT_EN
    logic [31:0]  stat_blocks;
    logic [31:0]  stat_bits;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wq_data[$];
    logic [5:0]  wq_bits[$];
    logic        wq_last[$];

    cavlc_stream_packer #(.NUM_CH(2), .CODE_W(128), .LEN_W(8), .OUT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_len(in_len),
        .flush_req(flush_req), .flush_done(flush_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_bits(out_bits)
`ifdef CAVLC_PACK_STAT_EN
        , .stat_blocks(stat_blocks), .stat_bits(stat_bits)
`endif
    );

    always #5 clk = ~clk;

    // Word collector: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            wq_data.push_back(out_data);
            wq_bits.push_back(out_bits);
            wq_last.push_back(out_last);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input int idx, input logic [31:0] d,
                              input logic [5:0] b, input logic l);
        if (wq_data.size() > idx) begin
            check_eq({tag, "_data"}, 64'(wq_data[idx]), 64'(d));
            check_eq({tag, "_bits"}, 64'(wq_bits[idx]), 64'(b));
            check_eq({tag, "_last"}, 64'(wq_last[idx]), 64'(l));
        end else begin
            check_eq({tag, "_missing"}, 64'(wq_data.size()), 64'(idx + 1));
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 2'b00;
        flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wq_data.delete();
        wq_bits.delete();
        wq_last.delete();
    endtask

    task automatic send(input int lane, input logic [127:0] code, input logic [7:0] len);
        bit ok = 1'b0;
        in_code[lane*128 +: 128] = code;
        in_len[lane*8 +: 8]      = len;
        in_valid[lane]           = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (in_ready[lane]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid[lane] = 1'b0;
        if (!ok) check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_flush(output int lat);
        bit got = 1'b0;
        lat       = 0;
        flush_req = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (flush_done) got = 1'b1;
            @(posedge clk);
            #1;
        end
        flush_req = 1'b0;
        if (!got) check_eq("flush_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check_eq("flush_pulse_len", 64'(flush_done), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int grants[$];
        in_code   = '0;
        in_len    = '0;
        out_ready = 1'b1;
        do_reset();

        // Reset values
        @(negedge clk);
        check_eq("rst_in_ready",   64'(in_ready),   64'd0);
        check_eq("rst_out_valid",  64'(out_valid),  64'd0);
        check_eq("rst_out_data",   64'(out_data),   64'd0);
        check_eq("rst_out_last",   64'(out_last),   64'd0);
        check_eq("rst_out_bits",   64'(out_bits),   64'd0);
        check_eq("rst_flush_done", 64'(flush_done), 64'd0);
`ifdef CAVLC_PACK_STAT_EN
        check_eq("rst_stat_blocks", 64'(stat_blocks), 64'd0);
        check_eq("rst_stat_bits",   64'(stat_bits),   64'd0);
`endif
        @(posedge clk);
        #1;

        // 5-bit code then flush: one partial word
        send(0, 128'h16, 8'd5);
        do_flush(lat);
        check_eq("a_words", 64'(wq_data.size()), 64'd1);
        check_word("a_w0", 0, 32'hB000_0000, 6'd5, 1'b1);

        // 40-bit code: one full word plus an 8-bit tail on flush
        do_reset();
        send(0, 128'hAB_CDEF_0123, 8'd40);
        do_flush(lat);
        check_eq("b_words", 64'(wq_data.size()), 64'd2);
        check_word("b_w0", 0, 32'hABCD_EF01, 6'd32, 1'b0);
        check_word("b_w1", 1, 32'h2300_0000, 6'd8, 1'b1);

        // Both lanes continuously valid: alternating grants, interleaved bytes
        do_reset();
        in_code[127:0]   = 128'h11;
        in_code[255:128] = 128'h22;
        in_len           = {8'd8, 8'd8};
        in_valid         = 2'b11;
        for (int c = 0; c < 60 && grants.size() < 4; c++) begin
            @(negedge clk);
            check_eq("rr_onehot", 64'($countones(in_ready) <= 1), 64'd1);
            if (in_ready[0]) grants.push_back(0);
            if (in_ready[1]) grants.push_back(1);
            @(posedge clk);
            #1;
        end
        in_valid = 2'b00;
        check_eq("rr_grant_cnt", 64'(grants.size()), 64'd4);
        for (int g = 0; g < 4 && g < grants.size(); g++) begin
            check_eq("rr_grant", 64'(grants[g]), 64'(g % 2));
        end
        repeat (6) @(posedge clk);
        #1;
        check_eq("rr_words", 64'(wq_data.size()), 64'd1);
        check_word("rr_w0", 0, 32'h1122_1122, 6'd32, 1'b0);

        // Backpressure: full word held 10 cycles, no acceptance, no bit loss
        do_reset();
        out_ready = 1'b0;
        send(0, 128'h01, 8'd8);
        send(0, 128'h02, 8'd8);
        send(0, 128'h03, 8'd8);
        send(0, 128'h04, 8'd8);
        in_code[127:0] = 128'h05;
        in_len[7:0]    = 8'd8;
        in_valid[0]    = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_out_data",  64'(out_data),  64'h0102_0304);
            check_eq("bp_in_ready",  64'(in_ready),  64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(0, 128'h05, 8'd8);
        do_flush(lat);
        check_eq("bp_words", 64'(wq_data.size()), 64'd2);
        check_word("bp_w0", 0, 32'h0102_0304, 6'd32, 1'b0);
        check_word("bp_w1", 1, 32'h0500_0000, 6'd8, 1'b1);

        // Zero-length block, then flush with an empty accumulator
        do_reset();
        send(1, 128'hFF, 8'd0);
        @(negedge clk);
        check_eq("z_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        do_flush(lat);
        check_eq("z_flush_lat", 64'(lat), 64'd2);
        check_eq("z_words", 64'(wq_data.size()), 64'd0);

        // Length above CODE_W is clamped to 128 bits
        do_reset();
        send(0, 128'hDEADBEEF_00000000_00000000_0000CAFE, 8'd255);
        do_flush(lat);
        check_eq("cl_words", 64'(wq_data.size()), 64'd4);
        check_word("cl_w0", 0, 32'hDEAD_BEEF, 6'd32, 1'b0);
        check_word("cl_w1", 1, 32'h0000_0000, 6'd32, 1'b0);
        check_word("cl_w3", 3, 32'h0000_CAFE, 6'd32, 1'b0);

        // Reset in the middle of packing a 100-bit block
        do_reset();
        out_ready = 1'b0;
        send(0, {128{1'b1}}, 8'd100);
        @(posedge clk);
        #1;
        check_eq("mr_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mr_out_valid", 64'(out_valid), 64'd0);
        check_eq("mr_out_data",  64'(out_data),  64'd0);
        check_eq("mr_out_bits",  64'(out_bits),  64'd0);
        check_eq("mr_out_last",  64'(out_last),  64'd0);
`ifdef CAVLC_PACK_STAT_EN
        check_eq("mr_stat_blocks", 64'(stat_blocks), 64'd0);
        check_eq("mr_stat_bits",   64'(stat_bits),   64'd0);
`endif
        @(posedge clk);
        #1;
        in_len   = {8'd8, 8'd8};
        in_valid = 2'b11;
        @(negedge clk);
        check_eq("mr_ptr_grant", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        check_eq("mr_no_stale_word", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
